// File: rtl/mt19937_pkg.sv
// MT19937 shared constants, tempering parameters and FSM state type.
// Imported by mt19937_temper and mt19937_prng.
package mt19937_pkg;

    localparam int          N        = 624;
    localparam logic [10:0] N_W      = 11'd624;
    localparam logic [9:0]  M_OFF    = 10'd397;
    localparam logic [9:0]  IDX_LAST = 10'd623;

    localparam logic [31:0] MATRIX_A  = 32'h9908_B0DF;
    localparam logic [31:0] UPPER     = 32'h8000_0000;
    localparam logic [31:0] LOWER     = 32'h7FFF_FFFF;
    localparam logic [31:0] INIT_MULT = 32'd1812433253;
    localparam logic [31:0] DEF_SEED  = 32'd5489;

    localparam int          TEMPER_U = 11;
    localparam int          TEMPER_S = 7;
    localparam int          TEMPER_T = 15;
    localparam int          TEMPER_L = 18;
    localparam logic [31:0] TEMPER_B = 32'h9D2C_5680;
    localparam logic [31:0] TEMPER_C = 32'hEFC6_0000;

    typedef enum logic [1:0] {
        S_IDLE,
        S_INIT,
        S_LOAD,
        S_GEN
    } state_t;

    // (a + b) mod N for indices already below N
    function automatic logic [9:0] wrap_add(
        input logic [9:0] a,
        input logic [9:0] b
    );
        logic [10:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= N_W) s = s - N_W;
        return s[9:0];
    endfunction

endpackage

// File: rtl/mt19937_temper.sv
// MT19937 output tempering, purely combinational.
// Maps one raw state word to the emitted random word.
module mt19937_temper
    import mt19937_pkg::*;
(
    input  logic [31:0] x_in,
    output logic [31:0] x_out
);

    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] c;

    // four-step xorshift tempering chain
    always_comb begin
        a     = x_in ^ (x_in >> TEMPER_U);
        b     = a ^ ((a << TEMPER_S) & TEMPER_B);
        c     = b ^ ((b << TEMPER_T) & TEMPER_C);
        x_out = c ^ (c >> TEMPER_L);
    end

endmodule

// File: rtl/mt19937_prng.sv
// MT19937 generator with valid/ready output stream.
// Define MT19937_DEFAULT_SEED_EN to auto-seed with DEFAULT_SEED after reset.
module mt19937_prng
    import mt19937_pkg::*;
#(
    parameter logic [31:0] DEFAULT_SEED = DEF_SEED
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] seed_val,
    input  logic        seed_start,
    input  logic        ready,
    output logic [31:0] r_num,
    output logic        valid,
    output logic        busy
);

    state_t      state;
    logic [9:0]  idx;
    logic [31:0] prev;
    logic [31:0] t_cur;
    logic [31:0] mt [N];

    logic [31:0] init_val;
    logic [9:0]  k;
    logic [9:0]  k1;
    logic [9:0]  km;
    logic [31:0] y;
    logic [31:0] tw;
    logic [31:0] tw_tmp;
    logic        mt_we;
    logic [31:0] mt_wd;

    // next init word; idx doubles as the init counter
    always_comb begin
        if (idx == 10'd0) begin
            init_val = prev;
        end else begin
            init_val = INIT_MULT * (prev ^ (prev >> 30))
                     + {22'd0, idx};
        end
    end

    // twist of the word to present next: 0 in LOAD, idx+1 in GEN
    always_comb begin
        k  = (state == S_LOAD) ? 10'd0 : wrap_add(idx, 10'd1);
        k1 = wrap_add(k, 10'd1);
        km = wrap_add(k, M_OFF);
        y  = (mt[k] & UPPER) | (mt[k1] & LOWER);
        tw = mt[km] ^ (y >> 1) ^ (y[0] ? MATRIX_A : 32'd0);
    end

    mt19937_temper u_temper (
        .x_in  (tw),
        .x_out (tw_tmp)
    );

    // state array write port: init words, or retire of the accepted twist
    always_comb begin
        mt_we = 1'b0;
        mt_wd = init_val;
        if (!seed_start) begin
            if (state == S_INIT) begin
                mt_we = 1'b1;
            end else if (state == S_GEN && ready) begin
                mt_we = 1'b1;
                mt_wd = t_cur;
            end
        end
    end

    // state storage, contents need no reset
    always_ff @(posedge clk) begin
        if (mt_we) mt[idx] <= mt_wd;
    end

    // control FSM with registered outputs; reseed wins in every state
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
            idx   <= 10'd0;
            prev  <= 32'd0;
            t_cur <= 32'd0;
            r_num <= 32'd0;
            valid <= 1'b0;
            busy  <= 1'b0;
        end else if (seed_start) begin
            state <= S_INIT;
            idx   <= 10'd0;
            prev  <= seed_val;
            valid <= 1'b0;
            busy  <= 1'b1;
        end else begin
            unique case (state)
                S_IDLE: begin
`ifdef MT19937_DEFAULT_SEED_EN
                    state <= S_INIT;
                    idx   <= 10'd0;
                    prev  <= DEFAULT_SEED;
                    busy  <= 1'b1;
`else
                    state <= S_IDLE;
`endif
                end
                S_INIT: begin
                    prev <= init_val;
                    if (idx == IDX_LAST) begin
                        state <= S_LOAD;
                        idx   <= 10'd0;
                    end else begin
                        idx <= idx + 10'd1;
                    end
                end
                S_LOAD: begin
                    t_cur <= tw;
                    r_num <= tw_tmp;
                    valid <= 1'b1;
                    busy  <= 1'b0;
                    state <= S_GEN;
                end
                S_GEN: begin
                    if (ready) begin
                        t_cur <= tw;
                        r_num <= tw_tmp;
                        idx   <= k;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mt19937_prng.sv
// Scoreboard bench for mt19937_prng.
// Build with MT19937_DEFAULT_SEED_EN defined to cover the auto-seed path.
module tb_mt19937_prng;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] seed_val = 32'd0;
    logic        seed_start = 1'b0;
    logic        ready = 1'b0;
    logic [31:0] r_num;
    logic        valid;
    logic        busy;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] expq [$];
    logic [31:0] ref_mt [624];
    int          ref_i = 624;

    logic        held = 1'b0;
    logic [31:0] held_val = 32'd0;

    mt19937_prng dut (
        .clk        (clk),
        .rst        (rst),
        .seed_val   (seed_val),
        .seed_start (seed_start),
        .ready      (ready),
        .r_num      (r_num),
        .valid      (valid),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    function automatic void check(
        input string       name,
        input logic [31:0] act,
        input logic [31:0] exp
    );
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endfunction

    task automatic ref_seed(input logic [31:0] s);
        ref_mt[0] = s;
        for (int i = 1; i < 624; i++) begin
            ref_mt[i] = 32'd1812433253
                      * (ref_mt[i-1] ^ (ref_mt[i-1] >> 30)) + 32'(i);
        end
        ref_i = 624;
    endtask

    task automatic ref_next(output logic [31:0] r);
        logic [31:0] y;
        if (ref_i >= 624) begin
            for (int kk = 0; kk < 624; kk++) begin
                y = (ref_mt[kk] & 32'h8000_0000)
                  | (ref_mt[(kk + 1) % 624] & 32'h7FFF_FFFF);
                ref_mt[kk] = ref_mt[(kk + 397) % 624] ^ (y >> 1)
                           ^ (y[0] ? 32'h9908_B0DF : 32'd0);
            end
            ref_i = 0;
        end
        y = ref_mt[ref_i];
        ref_i++;
        y = y ^ (y >> 11);
        y = y ^ ((y << 7) & 32'h9D2C_5680);
        y = y ^ ((y << 15) & 32'hEFC6_0000);
        y = y ^ (y >> 18);
        r = y;
    endtask

    // monitor: pop and compare every accepted word, check hold stability
    always @(negedge clk) begin
        if (!rst) begin
            held = 1'b0;
        end else begin
            if (held && valid) check("hold", r_num, held_val);
            held     = valid && !ready;
            held_val = r_num;
            if (valid && ready) begin
                if (expq.size() == 0) begin
                    check("unexpected_accept", 32'd1, 32'd0);
                end else begin
                    check("word", r_num, expq.pop_front());
                end
            end
        end
    end

    task automatic seed_issue(input logic [31:0] s);
        @(posedge clk);
        #1;
        seed_val   = s;
        seed_start = 1'b1;
        @(posedge clk);
        #1;
        seed_start = 1'b0;
        check("busy_after_start", {31'd0, busy}, 32'd1);
        check("valid_after_start", {31'd0, valid}, 32'd0);
    endtask

    task automatic wait_valid();
        int   c;
        logic busy_ok;
        c       = 0;
        busy_ok = 1'b1;
        while (!valid && c < 2000) begin
            if (!busy) busy_ok = 1'b0;
            @(posedge clk);
            #1;
            c++;
        end
        check("seed_latency", 32'(c), 32'd625);
        check("busy_held", {31'd0, busy_ok}, 32'd1);
        check("busy_done", {31'd0, busy}, 32'd0);
    endtask

    task automatic pull(input bit rnd);
        int guard;
        guard = 0;
        forever begin
            @(posedge clk);
            #1;
            guard++;
            if (expq.size() == 0) break;
            if (guard > 5000) begin
                check("pull_timeout", 32'(expq.size()), 32'd0);
                expq.delete();
                break;
            end
            ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        end
        ready = 1'b0;
    endtask

    task automatic push_ref(input int n);
        logic [31:0] w;
        for (int i = 0; i < n; i++) begin
            ref_next(w);
            expq.push_back(w);
        end
    endtask

    task automatic push_seed0();
        expq.push_back(32'd2357136044);
        expq.push_back(32'd2546248239);
        expq.push_back(32'd3071714933);
        expq.push_back(32'd3626093760);
    endtask

    initial begin
        #12;
        check("rst_r_num", r_num, 32'd0);
        check("rst_valid", {31'd0, valid}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
`ifdef MT19937_DEFAULT_SEED_EN
        check("auto_seed_busy", {31'd0, busy}, 32'd1);
`else
        check("idle_busy", {31'd0, busy}, 32'd0);
        check("idle_valid", {31'd0, valid}, 32'd0);
`endif

        seed_issue(32'd0);
        wait_valid();
        push_seed0();
        pull(1'b0);

        seed_issue(32'd5489);
        wait_valid();
        expq.push_back(32'd3499211612);
        expq.push_back(32'd581869302);
        pull(1'b0);

        seed_issue(32'd5489);
        wait_valid();
        ref_seed(32'd5489);
        push_ref(626);
        pull(1'b1);

        seed_issue(32'd0);
        wait_valid();
        ref_seed(32'd0);
        push_ref(10);
        pull(1'b0);
        check("valid_before_reseed", {31'd0, valid}, 32'd1);
        seed_issue(32'd0);
        wait_valid();
        push_seed0();
        pull(1'b0);

        seed_issue(32'd5489);
        repeat (100) @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        check("async_r_num", r_num, 32'd0);
        check("async_valid", {31'd0, valid}, 32'd0);
        check("async_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
`ifdef MT19937_DEFAULT_SEED_EN
        @(posedge clk);
        #1;
        wait_valid();
        expq.push_back(32'd3499211612);
        pull(1'b0);
`else
        repeat (5) @(posedge clk);
        #1;
        check("post_rst_busy", {31'd0, busy}, 32'd0);
        check("post_rst_valid", {31'd0, valid}, 32'd0);
`endif

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mt19937_prng.md
# mt19937_prng

Hardware MT19937 32-bit Mersenne Twister pseudo-random number generator with a valid/ready output stream. It is seeded through a start strobe plus seed word, runs the standard 624-word state initialisation, then emits tempered words bit-exact to the reference MT19937 algorithm. It sits as a stream source in front of consumers such as the single-port scratch `ram` block.

## Interface
- `DEFAULT_SEED`, 32'd5489: seed loaded automatically after reset when `MT19937_DEFAULT_SEED_EN` is defined.
- `clk` input 1: sole clock, rising-edge active.
- `rst` input 1: asynchronous, active-low reset.
- `seed_val` input 32: seed word, sampled with `seed_start`.
- `seed_start` input 1: one-cycle strobe that starts (re)seeding.
- `ready` input 1: consumer accepts `r_num` this cycle.
- `r_num` output 32: current tempered random word.
- `valid` output 1: `r_num` holds a valid word.
- `busy` output 1: initialisation in progress.

## Operation
- Constants: N=624, M=397, MATRIX_A=0x9908B0DF, UPPER=0x80000000, LOWER=0x7FFFFFFF, INIT_MULT=1812433253.
- State array `mt[0..623]` of 32-bit words plus a 10-bit index `idx`, which wraps 623 -> 0.
- FSM states:
  - IDLE: `valid`=0, `busy`=0.
  - INIT: `busy`=1.
  - LOAD: `busy`=1.
  - GEN: `valid`=1, `busy`=0.
- In any state, `seed_start`=1 at an edge goes to INIT and restarts from `seed_val`. The current word is discarded and the previous seed is abandoned.
- INIT writes one word per cycle:
  - i=0: `mt[0]=seed`.
  - i=1..623: `mt[i] = INIT_MULT*(mt[i-1] ^ (mt[i-1]>>30)) + i`, using the low 32 bits (mod 2^32).
  - After i=623, go to LOAD with `idx`=0.
- Twist of index k:
  - `y = (mt[k]&UPPER) | (mt[(k+1)%N]&LOWER)`.
  - `t(k) = mt[(k+M)%N] ^ (y>>1) ^ (y[0] ? MATRIX_A : 0)`.
- Tempering: `x ^= x>>11`, then `x ^= (x<<7)&0x9D2C5680`, then `x ^= (x<<15)&0xEFC60000`, then `x ^= x>>18`.
- LOAD registers `r_num = temper(t(0))` and goes to GEN.
- GEN handshake (`valid`&`ready` at an edge):
  - Write `mt[idx] = t(idx)`.
  - Register `r_num = temper(t(idx+1))`.
  - Set `idx = (idx+1)%N`.
  - No read-after-write forwarding is needed, because (k+1+M)%N never equals k.
- With `ready`=0, `r_num` and `valid` hold unchanged indefinitely.

## Timing
- Reset values: `r_num`=0, `valid`=0, `busy`=0, `idx`=0, state IDLE. `mt` contents are don't-care.
- Reset asserted mid-INIT or mid-GEN returns to IDLE (or to auto-seed, see Configuration).
- Seeding latency:
  - `seed_start` sampled at edge E.
  - `busy`=1 from E through E+625.
  - `valid`=1 and `busy`=0 from E+625.
  - INIT occupies 624 cycles, LOAD 1 cycle.
- Throughput is one word per cycle while `ready` is held high. `valid` never drops in GEN except on reseed or reset.
- `r_num` is driven from a register, not combinationally from `ready`.

## Configuration
- `MT19937_DEFAULT_SEED_EN` defined: on reset release, the FSM enters INIT with `DEFAULT_SEED` automatically, as if `seed_start` were seen at the first edge.
- Undefined: the FSM stays in IDLE until `seed_start`.

## Structure
- Package `mt19937_pkg` holds N, M, MATRIX_A, UPPER, LOWER, INIT_MULT, the tempering masks/shifts, and the FSM state enum typedef.
- One combinational sub-module, `mt19937_temper` (32-bit in -> 32-bit out), is instantiated once for the output path.
- State storage is an internal register array in the top level.

## Test plan
- Seed 0 via `seed_start`, `ready`=1 -> `busy` high for 625 cycles, then `r_num` = 2357136044, 2546248239, 3071714933, 3626093760 on consecutive cycles.
- Seed 5489 -> first word 3499211612, second 581869302.
- Seed 5489, read 624+2 words with `ready` toggled randomly -> every accepted word matches a C MT19937 model, including across the idx wrap; `r_num` stays stable while `ready`=0.
- `seed_start` with 0 during GEN after 10 words -> `valid` drops, 625-cycle reinit, then 2357136044 again.
- Assert `rst`=0 mid-INIT -> outputs 0 immediately (asynchronous), IDLE after release; with `MT19937_DEFAULT_SEED_EN` defined, the first word after reset release is 3499211612.
